weight_pingpong_buffer: RTL

Parametrised weight store between the DDR read stream and the MAC array, single clock domain. Packs IN_WIDTH-bit DDR beats LSB-first into OUT_WIDTH-bit weight words and writes them into two ping-pong banks, so one layer's weights load while the previous layer's are read. An internal fill/drain control FSM tracks bank occupancy and stored length, and supports replaying a bank several times for weight reuse across output tiles.

---
 rtl/weight_pingpong_buffer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/weight_pingpong_buffer.sv
// Weight store between the DDR read stream and the MAC array: packs beats LSB-first into weight words
// and holds them in banks that can be replayed. Define WEIGHT_PINGPONG_EN for two ping-pong banks.
module weight_pingpong_buffer #(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 1296,
    parameter int ADDR_W    = 8,
    parameter int REP_W     = 4
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 wr_start,
    input  logic [ADDR_W:0]      wr_len,
    input  logic [IN_WIDTH-1:0]  ddr_data_in,
    input  logic                 ddr_valid_in,
    output logic                 ddr_ready_out,
    output logic                 wr_done,
    input  logic                 rd_start,
    input  logic [ADDR_W:0]      rd_len,
    input  logic [REP_W-1:0]     rd_repeat,
    output logic [OUT_WIDTH-1:0] weight_data_out,
    output logic                 weight_valid_out,
    output logic                 rd_done,
    output logic [1:0]           bank_full,
    output logic                 cmd_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = ADDR_W + 1;
    localparam int ACC_W = OUT_WIDTH + IN_WIDTH - 1;
    localparam int CNT_W = $clog2(OUT_WIDTH + IN_WIDTH);
    localparam logic [CNT_W-1:0] OUT_CNT   = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] IN_CNT    = CNT_W'(IN_WIDTH);
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
`ifdef WEIGHT_PINGPONG_EN
    localparam bit TWO_BANKS = 1'b1;
`else
    localparam bit TWO_BANKS = 1'b0;
`endif

    typedef enum logic {W_IDLE, W_FILL} wstate_e;
    typedef enum logic {R_IDLE, R_RUN} rstate_e;

    wstate_e            wstate_q;
    logic               wr_sel_q;
    logic [LEN_W-1:0]   wr_len_q;
    logic [LEN_W-1:0]   word_cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_done_q;

    rstate_e            rstate_q;
    logic               rd_sel_q;
    logic [LEN_W-1:0]   rd_len_q;
    logic [LEN_W-1:0]   rd_addr_q;
    logic [REP_W-1:0]   rep_q;
    logic [REP_W-1:0]   pass_q;
    logic [OUT_WIDTH-1:0] weight_data_q;
    logic               weight_valid_q;
    logic               rd_done_q;

    logic [1:0]         bank_full_q;
    logic [LEN_W-1:0]   stored_len_q [2];
    logic               cmd_err_q;

    logic [OUT_WIDTH-1:0] bank0_mem [DEPTH];
`ifdef WEIGHT_PINGPONG_EN
    logic [OUT_WIDTH-1:0] bank1_mem [DEPTH];
`endif

    logic               wr_len_ok;
    logic               wr_accept;
    logic               wr_reject;
    logic               beat_fire;
    logic               word_we;
    logic               fill_last;
    logic [ADDR_W-1:0]  wr_addr;
    logic [LEN_W-1:0]   cur_stored;
    logic [LEN_W-1:0]   eff_len;
    logic [REP_W-1:0]   eff_rep;
    logic               rd_accept;
    logic               rd_reject;
    logic               rd_en;
    logic               rd_last_addr;
    logic               rd_last_pass;
    logic               drain_last;
    logic [ADDR_W-1:0]  rd_addr;
    logic [OUT_WIDTH-1:0] rd_word;

    assign wr_len_ok  = (wr_len != '0) && (wr_len <= DEPTH_LEN);
    assign wr_accept  = wr_start && (wstate_q == W_IDLE) && !bank_full_q[wr_sel_q] && wr_len_ok;
    assign wr_reject  = wr_start && !wr_accept;
    assign ddr_ready_out = (wstate_q == W_FILL) && (cnt_q < OUT_CNT);
    assign beat_fire  = ddr_valid_in && ddr_ready_out;
    // A full word in the accumulator blocks new beats for one cycle while it is written out.
    assign word_we    = (wstate_q == W_FILL) && (cnt_q >= OUT_CNT);
    assign fill_last  = word_we && ((word_cnt_q + LEN_W'(1)) == wr_len_q);
    assign wr_addr    = word_cnt_q[ADDR_W-1:0];

    assign cur_stored   = stored_len_q[rd_sel_q];
    assign eff_len      = (rd_len == '0) ? cur_stored : rd_len;
    assign eff_rep      = (rd_repeat == '0) ? REP_W'(1) : rd_repeat;
    assign rd_accept    = rd_start && (rstate_q == R_IDLE) && bank_full_q[rd_sel_q] && (eff_len <= cur_stored);
    assign rd_reject    = rd_start && !rd_accept;
    assign rd_en        = (rstate_q == R_RUN);
    assign rd_last_addr = (rd_addr_q == (rd_len_q - LEN_W'(1)));
    assign rd_last_pass = (pass_q == (rep_q - REP_W'(1)));
    assign drain_last   = rd_en && rd_last_addr && rd_last_pass;
    assign rd_addr      = rd_addr_q[ADDR_W-1:0];

`ifdef WEIGHT_PINGPONG_EN
    assign rd_word = rd_sel_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
`else
    assign rd_word = bank0_mem[rd_addr];
`endif

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q   <= W_IDLE;
            wr_sel_q   <= 1'b0;
            wr_len_q   <= '0;
            word_cnt_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            wr_done_q <= fill_last;
            case (wstate_q)
                W_IDLE: begin
                    if (wr_accept) begin
                        wstate_q   <= W_FILL;
                        wr_len_q   <= wr_len;
                        word_cnt_q <= '0;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                    end
                end
                W_FILL: begin
                    if (word_we) begin
                        word_cnt_q <= word_cnt_q + LEN_W'(1);
                        // Leftover bits after the final word are dropped, not carried into the next fill.
                        if (fill_last) begin
                            wstate_q <= W_IDLE;
                            wr_sel_q <= TWO_BANKS ? ~wr_sel_q : 1'b0;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            acc_q <= acc_q >> OUT_WIDTH;
                            cnt_q <= cnt_q - OUT_CNT;
                        end
                    end else if (beat_fire) begin
                        acc_q <= acc_q | ({{(ACC_W-IN_WIDTH){1'b0}}, ddr_data_in} << cnt_q);
                        cnt_q <= cnt_q + IN_CNT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (word_we && !wr_sel_q) begin
            bank0_mem[wr_addr] <= acc_q[OUT_WIDTH-1:0];
        end
`ifdef WEIGHT_PINGPONG_EN
        if (word_we && wr_sel_q) begin
            bank1_mem[wr_addr] <= acc_q[OUT_WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            rstate_q       <= R_IDLE;
            rd_sel_q       <= 1'b0;
            rd_len_q       <= '0;
            rd_addr_q      <= '0;
            rep_q          <= '0;
            pass_q         <= '0;
            weight_data_q  <= '0;
            weight_valid_q <= 1'b0;
            rd_done_q      <= 1'b0;
        end else begin
            weight_valid_q <= rd_en;
            rd_done_q      <= drain_last;
            if (rd_en) begin
                weight_data_q <= rd_word;
            end
            case (rstate_q)
                R_IDLE: begin
                    if (rd_accept) begin
                        rstate_q  <= R_RUN;
                        rd_len_q  <= eff_len;
                        rep_q     <= eff_rep;
                        rd_addr_q <= '0;
                        pass_q    <= '0;
                    end
                end
                R_RUN: begin
                    if (rd_last_addr) begin
                        rd_addr_q <= '0;
                        if (rd_last_pass) begin
                            rstate_q <= R_IDLE;
                            rd_sel_q <= TWO_BANKS ? ~rd_sel_q : 1'b0;
                        end else begin
                            pass_q <= pass_q + REP_W'(1);
                        end
                    end else begin
                        rd_addr_q <= rd_addr_q + LEN_W'(1);
                    end
                end
            endcase
        end
    end

    // Occupancy flags change only at clock edges, so a same-cycle start sees the old value.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            bank_full_q     <= '0;
            stored_len_q[0] <= '0;
            stored_len_q[1] <= '0;
            cmd_err_q       <= 1'b0;
        end else begin
            if (fill_last) begin
                bank_full_q[wr_sel_q]  <= 1'b1;
                stored_len_q[wr_sel_q] <= wr_len_q;
            end
            if (drain_last) begin
                bank_full_q[rd_sel_q] <= 1'b0;
            end
            cmd_err_q <= wr_reject | rd_reject;
        end
    end

    assign wr_done          = wr_done_q;
    assign weight_data_out  = weight_data_q;
    assign weight_valid_out = weight_valid_q;
    assign rd_done          = rd_done_q;
    assign bank_full        = bank_full_q;
    assign cmd_err          = cmd_err_q;

endmodule
